// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, NOP word,
// default reset PC and the IR payload struct.
package ifetch_defs;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ir_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Free-running count of instruction words written into the IR (wraps at 2^32).
module ifetch_perf_cnt
  import ifetch_defs::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_cnt
);

  logic [XLEN-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + XLEN'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// loads the IR. Optional fetch counter enabled by IFETCH_PERF_CNT_EN.
module ifetch_unit
  import ifetch_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  output logic [XLEN-1:0] pc_plus4
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_cnt
`endif
);

  localparam logic [XLEN-1:0] RESET_PC_A = word_align(RESET_PC);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  ir_entry_t       r_ir;
  logic            r_ir_valid;
  logic            r_imem_req;
  logic [XLEN-1:0] w_target;

  assign w_target = word_align(redirect_pc);

  // Redirect takes priority in every state; an outstanding request is always
  // completed (S_DRAIN) before the new target is fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC_A;
      r_req_addr <= RESET_PC_A;
      r_ir       <= '{instr: NOP_INSTR, pc: '0};
      r_ir_valid <= 1'b0;
      r_imem_req <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
          if (redirect) begin
            r_pc       <= w_target;
            r_req_addr <= w_target;
          end else begin
            r_req_addr <= r_pc;
          end
        end
        S_REQ: begin
          if (redirect) begin
            r_pc <= w_target;
            if (imem_ack) begin
              r_req_addr <= w_target;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            r_ir       <= '{instr: imem_rdata, pc: r_req_addr};
            r_pc       <= r_req_addr + XLEN'(4);
            r_ir_valid <= 1'b1;
            r_imem_req <= 1'b0;
            r_state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (redirect) begin
            r_ir_valid <= 1'b0;
            r_pc       <= w_target;
            r_req_addr <= w_target;
            r_imem_req <= 1'b1;
            r_state    <= S_REQ;
          end else if (!stall) begin
            r_ir_valid <= 1'b0;
            r_req_addr <= r_pc;
            r_imem_req <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            r_pc <= w_target;
          end
          if (imem_ack) begin
            r_req_addr <= redirect ? w_target : r_pc;
            r_state    <= S_REQ;
          end
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_req_addr;
  assign ir        = r_ir.instr;
  assign ir_pc     = r_ir.pc;
  assign ir_valid  = r_ir_valid;
  assign pc_plus4  = r_ir.pc + XLEN'(4);

`ifdef IFETCH_PERF_CNT_EN
  logic w_fetch_inc;

  // Only acks whose data lands in the IR are counted.
  assign w_fetch_inc = (r_state == S_REQ) && imem_ack && !redirect;

  ifetch_perf_cnt u_perf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_fetch_inc),
    .o_cnt (fetch_cnt)
  );
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory model answers requests, stimulus
// queues expected fetch addresses / IR loads, and a monitor pops and compares.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic [31:0] pc_plus4;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_ir_t;

  logic [31:0] exp_addr_q[$];
  exp_ir_t     exp_ir_q[$];

  int errors = 0;
  int checks = 0;
  logic mem_hold;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .pc_plus4    (pc_plus4)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : {8'hA5, a[23:0]};
  endfunction

  function automatic int mem_wait(input logic [31:0] a);
    if (a == 32'h8)  return 3;
    if (a == 32'h10) return 2;
    return 0;
  endfunction

  // Memory model: acks after mem_wait(addr) idle cycles, driven at negedge.
  initial begin
    int cnt;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n || !imem_req || mem_hold) begin
        imem_ack = 1'b0;
        cnt = 0;
      end else if (cnt == mem_wait(imem_addr)) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        cnt = 0;
      end else begin
        imem_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Monitor: handshake stability, fetch addresses and IR loads.
  initial begin
    logic        p_req, p_ack, p_valid, p_rst;
    logic [31:0] p_addr;
    exp_ir_t     e;
    p_req = 0; p_ack = 0; p_valid = 0; p_rst = 0; p_addr = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (p_rst && p_req && !p_ack) begin
          chk("req_held", 32'(imem_req), 32'h1);
          chk("addr_stable", imem_addr, p_addr);
        end
        if (imem_req && imem_ack) begin
          if (exp_addr_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
          else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (ir_valid && !p_valid) begin
          if (exp_ir_q.size() == 0) chk("unexpected_ir_load", ir, 32'hxxxx_xxxx);
          else begin
            e = exp_ir_q.pop_front();
            chk("ir", ir, e.instr);
            chk("ir_pc", ir_pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
          end
        end
      end
      p_req = imem_req; p_ack = imem_ack; p_valid = ir_valid;
      p_rst = rst_n; p_addr = imem_addr;
    end
  end

  task automatic push_ir(input logic [31:0] instr, input logic [31:0] pc);
    exp_ir_t e;
    e.instr = instr;
    e.pc = pc;
    exp_ir_q.push_back(e);
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) return;
    end
    chk("timeout_wait_req", imem_addr, a);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ir_valid) return;
    end
    chk("timeout_wait_valid", 32'(ir_valid), 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"},  32'(imem_req), 32'h0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_ir"},        ir, 32'h0);
    chk({tag, "_ir_pc"},     ir_pc, 32'h0);
    chk({tag, "_ir_valid"},  32'(ir_valid), 32'h0);
    chk({tag, "_pc_plus4"},  pc_plus4, 32'h4);
`ifdef IFETCH_PERF_CNT_EN
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("rst");

    // Sequential fetches: zero-wait, then 3-wait at 0x8, stall hold on 0x8.
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h10);
    push_ir(32'h2008_0005, 32'h0);
    push_ir(32'hA500_0004, 32'h4);
    push_ir(32'hA500_0008, 32'h8);
    push_ir(32'hA500_000C, 32'hC);
    @(negedge clk) rst_n = 1'b1;

    wait_req(32'h8);
    stall = 1'b1;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ir", ir, 32'hA500_0008);
      chk("stall_ir_pc", ir_pc, 32'h8);
      chk("stall_ir_valid", 32'(ir_valid), 32'h1);
      chk("stall_no_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("post_stall_req", 32'(imem_req), 32'h1);
    chk("post_stall_addr", imem_addr, 32'hC);

    // Redirect while 0x10 is pending: drained and dropped, then fetch 0x40.
    wait_req(32'h10);
    exp_addr_q.push_back(32'h40);
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    @(negedge clk) redirect = 1'b0;
    chk("drain_ir_valid", 32'(ir_valid), 32'h0);
    chk("drain_addr", imem_addr, 32'h10);

    // Redirect coincident with the ack of 0x40: data dropped, refetch 0x80.
    wait_req(32'h40);
    exp_addr_q.push_back(32'h80);
    push_ir(32'hA500_0080, 32'h80);
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    @(negedge clk) redirect = 1'b0;
    stall = 1'b1;
    chk("ackredir_ir_valid", 32'(ir_valid), 32'h0);
    chk("ackredir_addr", imem_addr, 32'h80);
    chk("ackredir_req", 32'(imem_req), 32'h1);

    // Redirect in S_FULL under stall flushes the IR.
    wait_valid();
    exp_addr_q.push_back(32'h100);
    push_ir(32'hA500_0100, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk) redirect = 1'b0;
    chk("flush_ir_valid", 32'(ir_valid), 32'h0);
    chk("flush_req", 32'(imem_req), 32'h1);
    chk("flush_addr", imem_addr, 32'h100);

    // PC wrap: fetch at 0xFFFFFFFC, then sequential fetch wraps to 0.
    wait_valid();
    exp_addr_q.push_back(32'hFFFF_FFFC);
    push_ir(32'hA5FF_FFFC, 32'hFFFF_FFFC);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    @(negedge clk) redirect = 1'b0;
    chk("wrap_target_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid();
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    exp_addr_q.push_back(32'h0);
    push_ir(32'h2008_0005, 32'h0);
    stall = 1'b0;
    @(negedge clk) stall = 1'b1;
    chk("wrap_req", 32'(imem_req), 32'h1);
    chk("wrap_addr", imem_addr, 32'h0);
    wait_valid();
    repeat (3) @(negedge clk);
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'h0);
    chk("ir_queue_empty", 32'(exp_ir_q.size()), 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd8);
`endif

    // Async reset while a request is outstanding.
    mem_hold = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    chk("pending_req", 32'(imem_req), 32'h1);
    chk("pending_addr", imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the MIPS core; directly upstream of the immediate extender and decoder.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Latches the returned word into the IR, which the extender and decoder consume.
- Supports downstream stall and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; once high, held until imem_ack
- imem_addr  out  32  word-aligned fetch address; stable while imem_req is high
- imem_ack  in  1  memory completes request this cycle; imem_rdata valid
- imem_rdata  in  32  instruction word
- stall  in  1  downstream cannot consume the IR this cycle
- redirect  in  1  single-cycle pulse: branch/jump taken
- redirect_pc  in  32  target PC; bits [1:0] ignored, forced to 0
- ir  out  32  instruction register (to extender/decoder)
- ir_pc  out  32  PC of the instruction in ir
- ir_valid  out  1  ir holds an unconsumed instruction
- pc_plus4  out  32  ir_pc + 4, combinational, for link/branch base

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, req_addr=RESET_PC, ir=0 (NOP), ir_pc=0, ir_valid=0, imem_req=0, state=S_IDLE.
- Consume rule: the IR is consumed in any cycle where ir_valid=1 and stall=0.
- States: S_IDLE, S_REQ, S_FULL, S_DRAIN.
- S_IDLE:
  - Entered only from reset; lasts 1 cycle after rst_n rises, then go to S_REQ.
  - On entry to S_REQ, req_addr<=pc.
  - A redirect here updates pc, and the first fetch uses redirect_pc.
- S_REQ:
  - imem_req=1, imem_addr=req_addr.
  - On imem_ack: ir<=imem_rdata, ir_pc<=req_addr, pc<=req_addr+4, ir_valid<=1, go to S_FULL.
  - No ack: hold state and address.
  - ir_valid is always 0 in this state.
- S_FULL:
  - imem_req=0.
  - If stall=0: ir_valid<=0, req_addr<=pc, go to S_REQ.
  - Otherwise hold ir, ir_pc and ir_valid unchanged.
- S_DRAIN:
  - imem_req=1 with the old req_addr until imem_ack.
  - The acked word is discarded; ir is not written and ir_valid stays 0.
  - Then req_addr<=pc and go to S_REQ.
- Redirect (highest priority over normal transitions):
  - In S_FULL: ir_valid<=0 (flush, even if stall=1), pc<=target, req_addr<=target, go to S_REQ.
  - In S_REQ without ack: pc<=target, go to S_DRAIN; the handshake must still complete.
  - In S_REQ with ack in the same cycle: discard data, ir_valid stays 0, pc<=target, req_addr<=target, stay in S_REQ.
  - In S_DRAIN without ack: pc<=target (latest wins), stay in S_DRAIN.
  - In S_DRAIN with ack: req_addr<=target, go to S_REQ.
- Throughput: with a zero-wait memory and stall=0, one instruction every 2 cycles. Fetch-to-ir_valid latency is 1 cycle after ack.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- A reset asserted mid-request drops imem_req asynchronously; memory must tolerate an abandoned request.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_cnt (32 bits), reset to 0.
  - Increments by 1 on every ack whose data is written to ir; discarded acks are not counted.
  - Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared include/package ifetch_defs:
  - state encodings S_IDLE=2'd0, S_REQ=2'd1, S_FULL=2'd2, S_DRAIN=2'd3
  - NOP_INSTR=32'h0000_0000
  - default RESET_PC
- Sub-module ifetch_perf_cnt (counter), instantiated only under IFETCH_PERF_CNT_EN.
- The FSM and PC stay in ifetch_unit.

Test Plan:
1. Reset release, zero-wait memory returning 32'h2008_0005, stall=0 -> imem_addr=0 two cycles later; ir=32'h2008_0005, ir_pc=0, pc_plus4=4, ir_valid=1; next request at address 4.
2. Memory acks after 3 wait cycles -> imem_req and imem_addr=0x8 stay stable for all 4 cycles; exactly one IR load.
3. IR valid with stall high for 5 cycles -> ir, ir_pc and ir_valid unchanged and imem_req=0; first request to the next address the cycle after stall falls.
4. Redirect to 32'h0000_0043 while a request to 0x10 is pending -> request at 0x10 completes and its data is dropped (ir_valid=0); next request at 0x40.
5. Redirect in the same cycle as an ack, and redirect during S_FULL with stall=1 -> no IR write / IR flushed; next imem_addr equals the target.
6. With IFETCH_PERF_CNT_EN: 10 fetches including 2 discarded -> fetch_cnt=8; async reset mid-request -> all outputs return to reset values immediately.
